// File: rtl/fp_image_loader_pkg.sv
// Shared types and helpers for the front-panel image loader.
package fp_image_loader_pkg;

  // Loader sequencing states, one per switch/button phase of the panel protocol
  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    LA_SET    = 4'd1,
    LA_PRESS  = 4'd2,
    LA_REL    = 4'd3,
    DEP_SET   = 4'd4,
    DEP_PRESS = 4'd5,
    DEP_REL   = 4'd6,
    ST_SET    = 4'd7,
    ST_PRESS  = 4'd8,
    ST_REL    = 4'd9,
    RUN_WAIT  = 4'd10,
    RUNNING   = 4'd11,
    HALTED    = 4'd12
  } fp_load_state_t;

  localparam int          FP_DEFAULT_HOLD     = 10;
  localparam logic [11:0] FP_DEFAULT_START_PC = 12'o0200;

  // True when nxt is the address the panel PC holds after depositing at prev
  // (the panel PC wraps 7777 -> 0000).
  function automatic logic fp_addr_follows(input logic [11:0] prev, input logic [11:0] nxt);
    logic [11:0] inc;
    inc = prev + 12'd1;
    return (nxt == inc);
  endfunction

  // True for the states whose duration is governed by the phase timer
  function automatic logic fp_is_timed(input fp_load_state_t s);
    logic timed;
    case (s)
      LA_SET, LA_PRESS, LA_REL,
      DEP_SET, DEP_PRESS, DEP_REL,
      ST_SET, ST_PRESS, ST_REL: timed = 1'b1;
      default:                  timed = 1'b0;
    endcase
    return timed;
  endfunction

endpackage

// File: rtl/fp_image_loader_if.sv
// Valid/ready word stream carrying (address, data, last) memory-image words.
interface fp_image_loader_if;
  logic        word_valid;
  logic [11:0] word_addr;
  logic [11:0] word_data;
  logic        word_last;
  logic        word_ready;

  modport master (
    output word_valid,
    output word_addr,
    output word_data,
    output word_last,
    input  word_ready
  );

  modport slave (
    input  word_valid,
    input  word_addr,
    input  word_data,
    input  word_last,
    output word_ready
  );
endinterface

// File: rtl/fp_image_loader_timer.sv
// Phase timer: loadable down-counter that flags the last cycle of a phase.
module fp_phase_timer
  import fp_image_loader_pkg::*;
#(
  parameter int HOLD_CYCLES = FP_DEFAULT_HOLD
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  output logic expired
);

  localparam int             W      = $clog2(HOLD_CYCLES + 1);
  localparam logic [W-1:0]   RELOAD = W'(HOLD_CYCLES - 1);
  localparam logic [W-1:0]   ONE    = W'(1);

  logic [W-1:0] count_r;

  // Load on phase entry, then count down to zero and hold there
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_r <= '0;
    end else if (load) begin
      count_r <= RELOAD;
    end else if (count_r != '0) begin
      count_r <= count_r - ONE;
    end else begin
      count_r <= count_r;
    end
  end

  // A phase loaded with HOLD_CYCLES-1 reaches zero in its HOLD_CYCLES-th cycle
  assign expired = (count_r == '0);

endmodule

// File: rtl/fp_image_loader.sv
// Replays a stream of memory-image words as front-panel load-address and
// deposit button sequences, then loads the start address, runs the CPU and
// waits for it to halt.
module fp_image_loader
  import fp_image_loader_pkg::*;
#(
  parameter int          HOLD_CYCLES = FP_DEFAULT_HOLD,
  parameter logic [11:0] START_PC    = FP_DEFAULT_START_PC
) (
  input  logic               clock,
  input  logic               reset,
  fp_image_loader_if.slave   word_if,
  input  logic               start,
  input  logic               run_led,
  output logic [12:0]        sw,
  output logic               load_pc_btn,
  output logic               deposit_btn,
  output logic               busy,
  output logic               done
);

  fp_load_state_t state_r;
  logic [11:0]    addr_r;
  logic [11:0]    data_r;
  logic           last_r;
  logic [11:0]    last_addr_r;
  logic           have_dep_r;

  logic idle_s;
  logic accept_s;
  logic empty_go_s;
  logic skip_s;
  logic timer_load_s;
  logic timer_expired_s;

  assign idle_s     = (state_r == IDLE);
  assign accept_s   = idle_s && word_if.word_valid;
  assign empty_go_s = idle_s && !word_if.word_valid && start;

  // The panel PC auto-increments after a deposit, so a word landing right
  // after the previous one needs no load-address sequence.
  assign skip_s = have_dep_r && fp_addr_follows(last_addr_r, word_if.word_addr);

  // Restart the timer whenever a new phase begins; reloading on the way into
  // an untimed state is harmless because the count is ignored there.
  assign timer_load_s = accept_s || empty_go_s || (fp_is_timed(state_r) && timer_expired_s);

  assign word_if.word_ready = idle_s && !reset;
  assign busy               = (state_r != IDLE) && (state_r != HALTED);

  fp_phase_timer #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_timer (
    .clock   (clock),
    .reset   (reset),
    .load    (timer_load_s),
    .expired (timer_expired_s)
  );

  // Loader FSM: sequences panel phases and drives registered panel outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      sw          <= 13'd0;
      load_pc_btn <= 1'b0;
      deposit_btn <= 1'b0;
      done        <= 1'b0;
      addr_r      <= 12'd0;
      data_r      <= 12'd0;
      last_r      <= 1'b0;
      last_addr_r <= 12'd0;
      have_dep_r  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (word_if.word_valid) begin
            addr_r <= word_if.word_addr;
            data_r <= word_if.word_data;
            last_r <= word_if.word_last;
            if (skip_s) begin
              state_r   <= DEP_SET;
              sw[11:0]  <= word_if.word_data;
            end else begin
              state_r   <= LA_SET;
              sw[11:0]  <= word_if.word_addr;
            end
          end else if (start) begin
            state_r  <= ST_SET;
            sw[11:0] <= START_PC;
          end else begin
            state_r <= IDLE;
          end
        end
        LA_SET: begin
          if (timer_expired_s) begin
            state_r     <= LA_PRESS;
            load_pc_btn <= 1'b1;
          end
        end
        LA_PRESS: begin
          if (timer_expired_s) begin
            state_r     <= LA_REL;
            load_pc_btn <= 1'b0;
          end
        end
        LA_REL: begin
          if (timer_expired_s) begin
            state_r  <= DEP_SET;
            sw[11:0] <= data_r;
          end
        end
        DEP_SET: begin
          if (timer_expired_s) begin
            state_r     <= DEP_PRESS;
            deposit_btn <= 1'b1;
          end
        end
        DEP_PRESS: begin
          if (timer_expired_s) begin
            state_r     <= DEP_REL;
            deposit_btn <= 1'b0;
          end
        end
        DEP_REL: begin
          if (timer_expired_s) begin
            last_addr_r <= addr_r;
            have_dep_r  <= 1'b1;
            if (last_r) begin
              state_r  <= ST_SET;
              sw[11:0] <= START_PC;
            end else begin
              state_r <= IDLE;
            end
          end
        end
        ST_SET: begin
          if (timer_expired_s) begin
            state_r     <= ST_PRESS;
            load_pc_btn <= 1'b1;
          end
        end
        ST_PRESS: begin
          if (timer_expired_s) begin
            state_r     <= ST_REL;
            load_pc_btn <= 1'b0;
          end
        end
        ST_REL: begin
          if (timer_expired_s) begin
            state_r <= RUN_WAIT;
            sw[12]  <= 1'b1;
          end
        end
        RUN_WAIT: begin
          if (run_led) begin
            state_r <= RUNNING;
          end
        end
        RUNNING: begin
          if (!run_led) begin
            state_r <= HALTED;
            sw      <= 13'd0;
            done    <= 1'b1;
          end
        end
        HALTED: begin
          if (start) begin
            state_r    <= IDLE;
            have_dep_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= IDLE;
          sw          <= 13'd0;
          load_pc_btn <= 1'b0;
          deposit_btn <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_image_loader.sv
// Directed bench for fp_image_loader with a behavioural front-panel model.
module tb_fp_image_loader;

  localparam int          H     = 10;
  localparam int          P     = 10;
  localparam int          LIMIT = 2000;
  localparam logic [11:0] SPC   = 12'o0200;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        run_led = 1'b0;
  logic [12:0] sw;
  logic        load_pc_btn;
  logic        deposit_btn;
  logic        busy;
  logic        done;

  fp_image_loader_if bus ();

  fp_image_loader #(
    .HOLD_CYCLES (H),
    .START_PC    (SPC)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .word_if     (bus),
    .start       (start),
    .run_led     (run_led),
    .sw          (sw),
    .load_pc_btn (load_pc_btn),
    .deposit_btn (deposit_btn),
    .busy        (busy),
    .done        (done)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (o%0o), expected %0d (o%0o)", name, act, act, exp, exp);
    end
  endtask

  // Front-panel model: records load-address events, deposits into memory
  logic [11:0] la_q[$];
  int          wq[$];
  int          overlap_cnt = 0;
  int          glitch_cnt = 0;
  logic [11:0] panel_mem [0:4095];
  logic [11:0] panel_pc = 12'd0;
  logic [11:0] held_sw = 12'd0;
  logic        prev_ld = 1'b0;
  logic        prev_dep = 1'b0;
  int          ld_w = 0;
  int          dep_w = 0;

  always @(negedge clock) begin
    if (load_pc_btn && deposit_btn) overlap_cnt++;
    if (load_pc_btn && !prev_ld) begin
      la_q.push_back(sw[11:0]);
      panel_pc = sw[11:0];
      held_sw  = sw[11:0];
    end
    if (deposit_btn && !prev_dep) begin
      panel_mem[panel_pc] = sw[11:0];
      panel_pc = panel_pc + 12'd1;
      held_sw  = sw[11:0];
    end
    if ((load_pc_btn || deposit_btn) && (sw[11:0] != held_sw)) glitch_cnt++;
    if (load_pc_btn) ld_w++;
    else if (prev_ld) begin wq.push_back(ld_w); ld_w = 0; end
    if (deposit_btn) dep_w++;
    else if (prev_dep) begin wq.push_back(dep_w); dep_w = 0; end
    prev_ld  = load_pc_btn;
    prev_dep = deposit_btn;
  end

  typedef struct {
    logic [11:0] addr;
    logic [11:0] data;
    logic        last;
    logic        exp_la;   // load-address sequence expected for this word
    int          exp_gap;  // cycles from this accept to the next word_ready
    int          exp_run;  // cycles from accept to sw[12] rise (last word only)
  } vec_t;

  localparam int NV = 7;
  vec_t vecs [NV];

  task automatic wait_ready(output time t);
    int k;
    k = 0;
    while (!bus.word_ready && k < LIMIT) begin @(negedge clock); k++; end
    check("word_ready_timeout", bus.word_ready, 1);
    t = $time;
  endtask

  task automatic send_word(input logic [11:0] a, input logic [11:0] d, input logic l, output time t);
    wait_ready(t);
    bus.word_valid = 1'b1;
    bus.word_addr  = a;
    bus.word_data  = d;
    bus.word_last  = l;
    @(posedge clock);
    @(negedge clock);
    bus.word_valid = 1'b0;
    bus.word_last  = 1'b0;
  endtask

  task automatic wait_run_switch(output time t);
    int k;
    k = 0;
    while (!sw[12] && k < LIMIT) begin @(negedge clock); k++; end
    check("run_switch_timeout", sw[12], 1);
    t = $time;
  endtask

  task automatic run_and_halt(input int run_cycles);
    check("busy_run_wait", busy, 1);
    check("btns_run_wait", {load_pc_btn, deposit_btn}, 0);
    repeat (3) @(negedge clock);
    check("sw12_run_wait_hold", sw[12], 1);
    run_led = 1'b1;
    repeat (run_cycles) @(negedge clock);
    check("done_while_running", done, 0);
    check("sw12_running", sw[12], 1);
    run_led = 1'b0;
    @(negedge clock);
    check("done_pulse", done, 1);
    check("sw_halted", sw, 0);
    check("busy_halted", busy, 0);
    check("ready_halted", bus.word_ready, 0);
    @(negedge clock);
    check("done_one_cycle", done, 0);
    repeat (3) @(negedge clock);
    check("ready_halted_hold", bus.word_ready, 0);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("ready_after_start", bus.word_ready, 1);
  endtask

  initial begin
    time t_acc, t_prev, t_run;
    int  la_base, img_start, wchk, j;

    vecs[0] = '{12'o0200, 12'o7402, 1'b1, 1'b1, 61, 91};
    vecs[1] = '{12'o0200, 12'o1111, 1'b0, 1'b1, 61, 0};
    vecs[2] = '{12'o0201, 12'o2222, 1'b0, 1'b0, 31, 0};
    vecs[3] = '{12'o0203, 12'o3333, 1'b1, 1'b1, 61, 91};
    vecs[4] = '{12'o0204, 12'o5555, 1'b0, 1'b1, 61, 0};
    vecs[5] = '{12'o7777, 12'o0123, 1'b0, 1'b1, 61, 0};
    vecs[6] = '{12'o0000, 12'o4567, 1'b1, 1'b0, 31, 61};

    bus.word_valid = 1'b0;
    bus.word_addr  = 12'd0;
    bus.word_data  = 12'd0;
    bus.word_last  = 1'b0;
    t_prev = 0;

    // Reset state
    #3;
    check("rst_sw", sw, 0);
    check("rst_btns", {load_pc_btn, deposit_btn}, 0);
    check("rst_ready", bus.word_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(negedge clock);
    #2 reset = 1'b0;
    @(negedge clock);
    check("ready_after_reset", bus.word_ready, 1);
    check("busy_after_reset", busy, 0);

    // Empty image: start pulse alone loads START_PC and runs
    la_base = la_q.size();
    start = 1'b1;
    t_acc = $time;
    @(negedge clock);
    start = 1'b0;
    check("empty_busy", busy, 1);
    wait_run_switch(t_run);
    check("empty_start_to_run", int'((t_run - t_acc) / P), 3 * H + 1);
    check("empty_la_count", la_q.size() - la_base, 1);
    if (la_q.size() > la_base) check("empty_la_start_pc", la_q[la_base], SPC);
    run_and_halt(50);

    // Table-driven images
    img_start = 0;
    la_base   = la_q.size();
    for (int i = 0; i < NV; i++) begin
      send_word(vecs[i].addr, vecs[i].data, vecs[i].last, t_acc);
      if (i != img_start)
        check("accept_gap", int'((t_acc - t_prev) / P), vecs[i-1].exp_gap);
      t_prev = t_acc;
      if (vecs[i].last) begin
        wait_run_switch(t_run);
        check("accept_to_run", int'((t_run - t_acc) / P), vecs[i].exp_run);
        j = la_base;
        for (int k = img_start; k <= i; k++) begin
          if (vecs[k].exp_la) begin
            if (j < la_q.size()) check("la_addr", la_q[j], vecs[k].addr);
            else                 check("la_missing", la_q.size(), j + 1);
            j++;
          end
        end
        check("la_count", la_q.size() - la_base, j - la_base + 1);
        if (j < la_q.size()) check("la_start_pc", la_q[j], SPC);
        for (int k = img_start; k <= i; k++)
          check("panel_mem", panel_mem[vecs[k].addr], vecs[k].data);
        run_and_halt(20 + i);
        img_start = i + 1;
        la_base   = la_q.size();
      end
    end

    wchk = 0;
    for (int i = wchk; i < wq.size(); i++) check("button_width", wq[i], H);
    check("button_overlap", overlap_cnt, 0);
    check("sw_stable_in_press", glitch_cnt, 0);

    // Reset in the middle of a deposit press clears outputs and skip history
    send_word(12'o0300, 12'o1111, 1'b0, t_acc);
    send_word(12'o0301, 12'o2222, 1'b0, t_acc);
    begin
      int k;
      k = 0;
      while (!deposit_btn && k < LIMIT) begin @(negedge clock); k++; end
      check("dep_press_timeout", deposit_btn, 1);
    end
    check("dep_press_sw", sw[11:0], 12'o2222);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_dep_btn", deposit_btn, 0);
    check("rst_mid_dep_sw", sw, 0);
    check("rst_mid_ld_btn", load_pc_btn, 0);
    @(negedge clock);
    #2 reset = 1'b0;
    @(negedge clock);
    check("ready_after_mid_reset", bus.word_ready, 1);
    la_base = la_q.size();
    send_word(12'o0301, 12'o3333, 1'b0, t_acc);
    wait_ready(t_run);
    check("post_reset_gap", int'((t_run - t_acc) / P), 6 * H + 1);
    check("post_reset_la_count", la_q.size() - la_base, 1);
    if (la_q.size() > la_base) check("post_reset_la_addr", la_q[la_base], 12'o0301);
    check("post_reset_mem", panel_mem[12'o0301], 12'o3333);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
